// File: rtl/arbiter_pkg.sv
// Shared types for the unified memory arbiter.
// Optional round-robin grant is enabled by ARBITER_ROUND_ROBIN_EN.
package arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_READ,
      DONE
   } arb_state_t;

   typedef enum logic {
      REQ_INST,
      REQ_DATA
   } arb_requester_t;

   // Wide enough for any sane bus; users slice the low lanes.
   localparam logic [127:0] BYTE_ENABLE_ALL = '1;

endpackage

// File: rtl/arbiter_grant_select.sv
// Winner selection between fetch and data requests.
// ARBITER_ROUND_ROBIN_EN alternates the winner on contention.
module arbiter_grant_select
   import arbiter_pkg::*;
(
   input  logic           inst_req_i,
   input  logic           data_req_i,
   input  arb_requester_t last_grant_i,
   output logic           any_req_o,
   output logic           contend_o,
   output arb_requester_t winner_o
);

   always_comb begin
      any_req_o = inst_req_i | data_req_i;
      contend_o = inst_req_i & data_req_i;
      winner_o  = data_req_i ? REQ_DATA : REQ_INST;
`ifdef ARBITER_ROUND_ROBIN_EN
      if (contend_o) begin
         winner_o = (last_grant_i == REQ_INST) ? REQ_DATA : REQ_INST;
      end
`endif
   end

`ifndef ARBITER_ROUND_ROBIN_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/unified_memory_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Define ARBITER_ROUND_ROBIN_EN for alternating priority on contention.
module unified_memory_arbiter
   import arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   inst_address,
   input  logic                    inst_read_enable,
   output logic                    inst_wait_req,
   output logic                    inst_valid,
   output logic [DATA_WIDTH-1:0]   inst_read_data,
   input  logic [ADDR_WIDTH-1:0]   data_address,
   input  logic                    data_read_enable,
   input  logic                    data_write_enable,
   input  logic [DATA_WIDTH/8-1:0] data_byte_enable,
   input  logic [DATA_WIDTH-1:0]   data_write_data,
   output logic                    data_wait_req,
   output logic                    data_valid,
   output logic [DATA_WIDTH-1:0]   data_read_data,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic                    mem_read_enable,
   output logic                    mem_write_enable,
   output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
   output logic [DATA_WIDTH-1:0]   mem_write_data,
   input  logic                    mem_wait_req,
   input  logic                    mem_valid,
   input  logic [DATA_WIDTH-1:0]   mem_read_data
);

   localparam int BE_W = DATA_WIDTH / 8;

   arb_state_t             state_q, state_d;
   arb_requester_t         grant_q, grant_d;
   arb_requester_t         last_grant;
   arb_requester_t         winner;
   logic                   any_req, contend;
   logic                   inst_req, data_req, granted_en;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   re_q, re_d, we_q, we_d;
   logic [BE_W-1:0]        be_q, be_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic                   ivalid_q, ivalid_d, dvalid_q, dvalid_d;
   logic [DATA_WIDTH-1:0]  irdata_q, irdata_d, drdata_q, drdata_d;
   logic                   capture;

   assign inst_req = inst_read_enable;
   assign data_req = data_read_enable | data_write_enable;

`ifdef ARBITER_ROUND_ROBIN_EN
   arb_requester_t last_grant_q, last_grant_d;
   assign last_grant = last_grant_q;
`else
   assign last_grant = REQ_INST;
`endif

   arbiter_grant_select u_grant (
      .inst_req_i   (inst_req),
      .data_req_i   (data_req),
      .last_grant_i (last_grant),
      .any_req_o    (any_req),
      .contend_o    (contend),
      .winner_o     (winner)
   );

   assign granted_en = (grant_q == REQ_DATA) ? data_req : inst_req;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      re_d     = re_q;
      we_d     = we_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      ivalid_d = 1'b0;
      dvalid_d = 1'b0;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      capture  = 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = winner;
               state_d = ISSUE;
               if (winner == REQ_DATA) begin
                  addr_d  = data_address;
                  we_d    = data_write_enable;
                  re_d    = ~data_write_enable;
                  be_d    = data_byte_enable;
                  wdata_d = data_write_data;
               end else begin
                  addr_d  = inst_address;
                  we_d    = 1'b0;
                  re_d    = 1'b1;
                  be_d    = BYTE_ENABLE_ALL[BE_W-1:0];
                  wdata_d = '0;
               end
`ifdef ARBITER_ROUND_ROBIN_EN
               if (contend) last_grant_d = winner;
`endif
            end
         end
         ISSUE: begin
            if (!mem_wait_req) begin
               re_d = 1'b0;
               we_d = 1'b0;
               if (we_q) begin
                  state_d = DONE;
               end else if (mem_valid) begin
                  capture = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = WAIT_READ;
               end
            end
         end
         WAIT_READ: begin
            if (mem_valid) begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A requester that let go mid-flight gets neither data nor a pulse.
      if (capture && granted_en) begin
         if (grant_q == REQ_DATA) begin
            drdata_d = mem_read_data;
            dvalid_d = 1'b1;
         end else begin
            irdata_d = mem_read_data;
            ivalid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         grant_q  <= REQ_INST;
         addr_q   <= '0;
         re_q     <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
         ivalid_q <= 1'b0;
         dvalid_q <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         re_q     <= re_d;
         we_q     <= we_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         ivalid_q <= ivalid_d;
         dvalid_q <= dvalid_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
      end
   end

`ifdef ARBITER_ROUND_ROBIN_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) last_grant_q <= REQ_INST;
      else        last_grant_q <= last_grant_d;
   end
`endif

   assign inst_wait_req = inst_req &
      ~(state_q == DONE && grant_q == REQ_INST);
   assign data_wait_req = data_req &
      ~(state_q == DONE && grant_q == REQ_DATA);

   assign mem_address      = addr_q;
   assign mem_read_enable  = re_q;
   assign mem_write_enable = we_q;
   assign mem_byte_enable  = be_q;
   assign mem_write_data   = wdata_q;
   assign inst_valid       = ivalid_q;
   assign inst_read_data   = irdata_q;
   assign data_valid       = dvalid_q;
   assign data_read_data   = drdata_q;

endmodule

// File: doc/unified_memory_arbiter.md
Name: unified_memory_arbiter

Overview:
- Shares one external memory port between the core's instruction-fetch bus and its data bus.
- Used for unified-memory targets, in place of separate text and data memories.
- Each requester sees a wait-request/valid handshake; the memory side carries one outstanding transaction at a time.
- Sits between riscv_core and a single memory-bus instance in the toplevel.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses; byte-enable width is DATA_WIDTH/8

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- inst_address  in  ADDR_WIDTH  fetch address (pc)
- inst_read_enable  in  1  fetch request
- inst_wait_req  out  1  fetch not yet complete
- inst_valid  out  1  inst_read_data valid this cycle
- inst_read_data  out  DATA_WIDTH  fetched word
- data_address  in  ADDR_WIDTH  load/store address
- data_read_enable  in  1  load request
- data_write_enable  in  1  store request
- data_byte_enable  in  DATA_WIDTH/8  store byte lanes
- data_write_data  in  DATA_WIDTH  store data
- data_wait_req  out  1  data access not yet complete
- data_valid  out  1  data_read_data valid this cycle
- data_read_data  out  DATA_WIDTH  load result
- mem_address  out  ADDR_WIDTH  memory address
- mem_read_enable  out  1  memory read strobe
- mem_write_enable  out  1  memory write strobe
- mem_byte_enable  out  DATA_WIDTH/8  memory byte lanes
- mem_write_data  out  DATA_WIDTH  memory write data
- mem_wait_req  in  1  memory has not accepted the request
- mem_valid  in  1  memory read data valid
- mem_read_data  in  DATA_WIDTH  memory read data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT_READ, DONE. Reset value is IDLE; reset is asynchronous, active-low.
- Reset values: all mem_* outputs 0; *_valid 0; *_read_data 0.
- *_wait_req is combinational: equals (requester enable) AND NOT (state==DONE AND granted==that requester). No reset value of its own.
- IDLE, arbitration:
  - If any request is pending, latch winner id, address, write data and byte enables; next state is ISSUE.
  - With no request, stay in IDLE.
  - Fixed priority: data beats inst.
  - Instruction reads use byte enables all ones.
  - data_read_enable and data_write_enable both set: treated as a write.
- ISSUE:
  - mem_* outputs are registered from the latched values and held stable while mem_wait_req=1.
  - On acceptance (mem_wait_req=0), strobes drop next cycle.
  - Accepted write goes to DONE.
  - Accepted read goes to WAIT_READ, or straight to DONE if mem_valid=1 in the same cycle.
- WAIT_READ: on mem_valid=1, register mem_read_data into the granted requester's read_data; next state is DONE.
- DONE: lasts one cycle.
  - Granted requester sees wait_req=0.
  - For reads, its *_valid=1 in this cycle only.
  - Next state is IDLE.
- Minimum latency is 3 cycles from request to wait_req low: IDLE, ISSUE, DONE, with zero-wait memory and same-cycle valid.
- Requesters must hold their request stable while their wait_req=1.
- If a requester drops its enable mid-transaction, the memory transaction still completes and the result is discarded; no valid pulse is given.
- mem_valid outside WAIT_READ/ISSUE is ignored.
- The losing requester stays stalled with wait_req=1 and is served at the next IDLE.
- Reset asserted mid-transaction: return to IDLE immediately and drop strobes; the memory transaction is abandoned.

Optional Feature:
- Macro: ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A last_grant register (reset value: inst) alternates priority when both requesters are pending in IDLE.
  - The first contention after reset goes to data.
- Undefined: fixed data-over-inst priority and no last_grant register.

Decomposition:
- Package arbiter_pkg (in constants.sv style) holds:
  - enum arb_state_t {IDLE, ISSUE, WAIT_READ, DONE}
  - enum arb_requester_t {REQ_INST, REQ_DATA}
  - BYTE_ENABLE_ALL constant
- One sub-module, arbiter_grant_select: combinational winner selection from the two requests plus last_grant; round-robin is gated by the macro.

Test Plan:
- Single fetch: inst_read_enable=1, addr 0x00000100; memory has zero wait and returns 0x00000013 same cycle → inst_valid=1 with inst_read_data=0x00000013 in cycle 3; inst_wait_req low in that cycle only.
- Store with stall: data_write_enable=1, addr 0x00002000, byte_enable 0b0011, data 0xDEADBEEF; mem_wait_req=1 for 4 cycles → mem_* held constant for all 4 cycles; data_wait_req falls one cycle after acceptance; mem_write_enable drops after acceptance.
- Contention: fetch 0x0 and load 0x1000 both asserted at the same edge → load issued first and fetch second.
  - With ARBITER_ROUND_ROBIN_EN: a second contention grants fetch first.
- Delayed read: load 0x1004, mem_valid arrives 5 cycles after acceptance with 0x12345678 → data_valid for exactly 1 cycle with 0x12345678; inst outputs unchanged.
- Reset mid-read (reset=0 during WAIT_READ) → all mem_* and *_valid are 0 asynchronously; after release, a new fetch completes normally.
- Abandoned request: inst_read_enable dropped during ISSUE → transaction completes, inst_valid stays 0, FSM returns to IDLE.
